// File: rtl/serial_master_port.sv
// -----------------------------------------------------------------------------
// serial_master_port
//
// Master-side serial bus port. Converts one parallel read/write request from
// the local core into the 1-bit serial protocol used by the two-master
// arbiter: bus request/grant, device-address phase (MSB first), ack check,
// memory-address phase, then either serial write data or serial read-data
// capture, a one-cycle completion pulse and a bus-release wait.
//
// Optional feature (compile-time macro):
//   SMP_TIMEOUT_EN  - when defined, a stall counter aborts a transfer that
//                     makes no progress for TIMEOUT_CYCLES cycles (rsp_err
//                     = 2'b11). When undefined, the port waits indefinitely.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   req_valid / req_ready    core request handshake (req_ready = port idle)
//   req_mode                 1 = write, 0 = read
//   req_dev/addr/wdata       target device, local address, write data
//   rsp_valid                one-cycle completion pulse
//   rsp_err                  00 ok, 01 nack, 10 grant lost, 11 timeout
//   rsp_rdata                read data, updated only by a successful read
//   breq / bgrant            bus request / grant
//   mode                     transfer direction presented to the arbiter
//   wr_bus, master_valid,
//   slave_ready              outgoing serial bit handshake
//   rd_bus, slave_valid,
//   master_ready             incoming serial bit handshake
//   ack                      arbiter slave-found indication
//
// All outputs are registered; their next values are decoded from the
// next-state values so they line up exactly with the state register.
// -----------------------------------------------------------------------------
module serial_master_port #(
    parameter int DEV_WIDTH      = 5,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mode,
    input  logic [DEV_WIDTH-1:0]  req_dev,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  breq,
    input  logic                  bgrant,
    output logic                  mode,
    output logic                  wr_bus,
    output logic                  master_valid,
    input  logic                  slave_ready,
    input  logic                  rd_bus,
    input  logic                  slave_valid,
    output logic                  master_ready,
    input  logic                  ack
);

    localparam int MAX_BITS_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAX_BITS    = (MAX_BITS_AD > DEV_WIDTH) ? MAX_BITS_AD : DEV_WIDTH;
    localparam int CNT_W       = $clog2(MAX_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEV_LAST  = CNT_W'(DEV_WIDTH - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_LOST    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // The arbiter keeps a master connected for 26 cycles; address plus data
    // must fit inside that window. The shift logic also needs at least two
    // address bits (one goes out during the ack check).
    generate
        if (ADDR_WIDTH + DATA_WIDTH > 26) begin : g_window_chk
            $fatal(1, "serial_master_port: ADDR_WIDTH + DATA_WIDTH exceeds the 26-cycle arbiter window");
        end
        if (ADDR_WIDTH < 2 || DATA_WIDTH < 1 || DEV_WIDTH < 1) begin : g_width_chk
            $fatal(1, "serial_master_port: unsupported field width");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
            $fatal(1, "serial_master_port: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        REQ       = 4'd1,
        DEV_ADDR  = 4'd2,
        ACK_CHECK = 4'd3,
        MEM_ADDR  = 4'd4,
        WDATA     = 4'd5,
        RDATA     = 4'd6,
        DONE      = 4'd7,
        RELEASE   = 4'd8
    } state_t;

    // State and captured request fields
    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    mode_r;
    logic [DEV_WIDTH-1:0]    dev_sh_r;
    logic [ADDR_WIDTH-1:0]   addr_sh_r;
    logic [DATA_WIDTH-1:0]   wdata_sh_r;
    logic [DATA_WIDTH-1:0]   rx_sh_r;

    // Registered outputs
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [1:0]              rsp_err_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    breq_r;
    logic                    mode_out_r;
    logic                    wr_bus_r;
    logic                    master_valid_r;
    logic                    master_ready_r;

    // Next-state values
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic                    mode_nxt_s;
    logic [DEV_WIDTH-1:0]    dev_nxt_s;
    logic [ADDR_WIDTH-1:0]   addr_nxt_s;
    logic [DATA_WIDTH-1:0]   wdata_nxt_s;
    logic [DATA_WIDTH-1:0]   rx_nxt_s;
    logic [1:0]              err_s;

    // Next output values
    logic                    req_ready_nxt_s;
    logic                    rsp_valid_nxt_s;
    logic [1:0]              rsp_err_nxt_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt_s;
    logic                    breq_nxt_s;
    logic                    mode_out_nxt_s;
    logic                    wr_bus_nxt_s;
    logic                    master_valid_nxt_s;
    logic                    master_ready_nxt_s;

    logic                    wr_xfer_s;
    logic                    rd_xfer_s;
    logic                    timeout_hit_s;

    assign wr_xfer_s = master_valid_r && slave_ready;
    assign rd_xfer_s = master_ready_r && slave_valid;

`ifdef SMP_TIMEOUT_EN
    localparam int                 STALL_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

    logic [STALL_W-1:0] stall_r;
    logic               stall_active_s;

    assign stall_active_s = (state_r inside {REQ, DEV_ADDR, ACK_CHECK, MEM_ADDR, WDATA, RDATA});
    // The stall limit is hit when this cycle would make the count reach
    // TIMEOUT_CYCLES; a transfer in the same cycle takes precedence.
    assign timeout_hit_s  = (stall_r == STALL_LAST);

    // Stall counter: cleared outside the active states and on every bit transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= '0;
        end else if (!stall_active_s || wr_xfer_s || rd_xfer_s) begin
            stall_r <= '0;
        end else if (stall_r != STALL_LAST) begin
            stall_r <= stall_r + STALL_ONE;
        end else begin
            stall_r <= stall_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state, bit counter and shift-register update logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mode_nxt_s  = mode_r;
        dev_nxt_s   = dev_sh_r;
        addr_nxt_s  = addr_sh_r;
        wdata_nxt_s = wdata_sh_r;
        rx_nxt_s    = rx_sh_r;
        err_s       = ERR_OK;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    state_nxt_s = REQ;
                    cnt_nxt_s   = '0;
                    mode_nxt_s  = req_mode;
                    dev_nxt_s   = req_dev;
                    addr_nxt_s  = req_addr;
                    wdata_nxt_s = req_wdata;
                    rx_nxt_s    = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (bgrant) begin
                    state_nxt_s = DEV_ADDR;
                    cnt_nxt_s   = '0;
                end else if (timeout_hit_s) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            DEV_ADDR: begin
                // ack is deliberately not looked at while the device address is sent
                if (!bgrant) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_LOST;
                end else if (wr_xfer_s) begin
                    dev_nxt_s = dev_sh_r << 1;
                    if (cnt_r == DEV_LAST) begin
                        state_nxt_s = ACK_CHECK;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else if (timeout_hit_s) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = DEV_ADDR;
                end
            end
            ACK_CHECK: begin
                // The address MSB is already on wr_bus; with ack it counts as address bit 0
                if (!bgrant) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_LOST;
                end else if (wr_xfer_s) begin
                    if (ack) begin
                        addr_nxt_s  = addr_sh_r << 1;
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = MEM_ADDR;
                    end else begin
                        state_nxt_s = DONE;
                        err_s       = ERR_NACK;
                    end
                end else if (timeout_hit_s) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = ACK_CHECK;
                end
            end
            MEM_ADDR: begin
                if (!bgrant) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_LOST;
                end else if (wr_xfer_s) begin
                    addr_nxt_s = addr_sh_r << 1;
                    if (cnt_r == ADDR_LAST) begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = mode_r ? WDATA : RDATA;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else if (timeout_hit_s) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = MEM_ADDR;
                end
            end
            WDATA: begin
                if (!bgrant) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_LOST;
                end else if (wr_xfer_s) begin
                    wdata_nxt_s = wdata_sh_r << 1;
                    if (cnt_r == DATA_LAST) begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = DONE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else if (timeout_hit_s) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = WDATA;
                end
            end
            RDATA: begin
                if (!bgrant) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_LOST;
                end else if (rd_xfer_s) begin
                    rx_nxt_s = (rx_sh_r << 1) | DATA_WIDTH'(rd_bus);
                    if (cnt_r == DATA_LAST) begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = DONE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else if (timeout_hit_s) begin
                    state_nxt_s = DONE;
                    err_s       = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = RDATA;
                end
            end
            DONE: begin
                state_nxt_s = RELEASE;
                cnt_nxt_s   = '0;
            end
            RELEASE: begin
                // Wait for the arbiter to drop ack before taking new work
                if (!ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Output decode from the next state so every output is a clean flop
    always_comb begin
        req_ready_nxt_s    = (state_nxt_s == IDLE);
        breq_nxt_s         = (state_nxt_s inside {REQ, DEV_ADDR, ACK_CHECK, MEM_ADDR, WDATA, RDATA});
        mode_out_nxt_s     = (state_nxt_s inside {REQ, DEV_ADDR, ACK_CHECK, MEM_ADDR, WDATA, RDATA, DONE})
                             ? mode_nxt_s : 1'b0;
        master_valid_nxt_s = (state_nxt_s inside {DEV_ADDR, ACK_CHECK, MEM_ADDR, WDATA});
        master_ready_nxt_s = (state_nxt_s == RDATA);
        rsp_valid_nxt_s    = (state_nxt_s == DONE);
        rsp_err_nxt_s      = (state_nxt_s == DONE) ? err_s : ERR_OK;
        rsp_rdata_nxt_s    = rsp_rdata_r;
        wr_bus_nxt_s       = 1'b0;
        case (state_nxt_s)
            DEV_ADDR:  wr_bus_nxt_s = dev_nxt_s[DEV_WIDTH-1];
            ACK_CHECK: wr_bus_nxt_s = addr_nxt_s[ADDR_WIDTH-1];
            MEM_ADDR:  wr_bus_nxt_s = addr_nxt_s[ADDR_WIDTH-1];
            WDATA:     wr_bus_nxt_s = wdata_nxt_s[DATA_WIDTH-1];
            default:   wr_bus_nxt_s = 1'b0;
        endcase
        // Read data is published only by a read that completed without error
        if ((state_r == RDATA) && (state_nxt_s == DONE) && (err_s == ERR_OK)) begin
            rsp_rdata_nxt_s = rx_nxt_s;
        end else begin
            rsp_rdata_nxt_s = rsp_rdata_r;
        end
    end

    // State, captured fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            mode_r         <= 1'b0;
            dev_sh_r       <= '0;
            addr_sh_r      <= '0;
            wdata_sh_r     <= '0;
            rx_sh_r        <= '0;
            req_ready_r    <= 1'b1;
            rsp_valid_r    <= 1'b0;
            rsp_err_r      <= 2'b00;
            rsp_rdata_r    <= '0;
            breq_r         <= 1'b0;
            mode_out_r     <= 1'b0;
            wr_bus_r       <= 1'b0;
            master_valid_r <= 1'b0;
            master_ready_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            mode_r         <= mode_nxt_s;
            dev_sh_r       <= dev_nxt_s;
            addr_sh_r      <= addr_nxt_s;
            wdata_sh_r     <= wdata_nxt_s;
            rx_sh_r        <= rx_nxt_s;
            req_ready_r    <= req_ready_nxt_s;
            rsp_valid_r    <= rsp_valid_nxt_s;
            rsp_err_r      <= rsp_err_nxt_s;
            rsp_rdata_r    <= rsp_rdata_nxt_s;
            breq_r         <= breq_nxt_s;
            mode_out_r     <= mode_out_nxt_s;
            wr_bus_r       <= wr_bus_nxt_s;
            master_valid_r <= master_valid_nxt_s;
            master_ready_r <= master_ready_nxt_s;
        end
    end

    assign req_ready    = req_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_err      = rsp_err_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign breq         = breq_r;
    assign mode         = mode_out_r;
    assign wr_bus       = wr_bus_r;
    assign master_valid = master_valid_r;
    assign master_ready = master_ready_r;

endmodule

// File: tb/tb_serial_master_port.sv
// -----------------------------------------------------------------------------
// tb_serial_master_port
//
// Directed bench for serial_master_port. A small arbiter/slave model lives in
// the tick() task: it drives bgrant/ack/slave_ready/slave_valid/rd_bus on the
// falling edge from the port's current outputs and logs every outgoing bit
// that will transfer on the following rising edge.
// -----------------------------------------------------------------------------
module tb_serial_master_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [4:0]  req_dev;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_err;
    logic [7:0]  rsp_rdata;
    logic        breq;
    logic        bgrant;
    logic        mode;
    logic        wr_bus;
    logic        master_valid;
    logic        slave_ready;
    logic        rd_bus;
    logic        slave_valid;
    logic        master_ready;
    logic        ack;

    serial_master_port #(
        .DEV_WIDTH      (5),
        .ADDR_WIDTH     (12),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_dev      (req_dev),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .breq         (breq),
        .bgrant       (bgrant),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .rd_bus       (rd_bus),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .ack          (ack)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;

    // arbiter / slave model configuration and observations
    logic        grant_en;
    logic        ack_en;
    int          grant_drop_at;
    int          rdy_stall_at;
    int          ack_linger;
    int          linger_cnt;
    logic [7:0]  rx_byte;
    int          rd_idx;
    logic [31:0] wr_log;
    int          wr_count;
    int          rsp_count;
    logic [1:0]  last_err;
    logic [7:0]  last_rdata;
    logic        last_breq;
    logic        last_mv;
    int          mv_in_rd;
    int          accept_count;
    logic        accept_pending;
    logic        auto_clear;
    int          zero_ticks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (auto_clear && accept_pending) req_valid = 1'b0;
        accept_pending = req_valid && req_ready;
        if (accept_pending) accept_count++;
        if (rsp_valid) begin
            rsp_count++;
            last_err   = rsp_err;
            last_rdata = rsp_rdata;
            last_breq  = breq;
            last_mv    = master_valid;
        end
        if (master_ready && master_valid) mv_in_rd++;
        if (grant_drop_at >= 0 && wr_count >= grant_drop_at) grant_en = 1'b0;
        bgrant = grant_en && breq;
        ack    = ack_en && (breq || linger_cnt > 0);
        if (breq) linger_cnt = ack_linger;
        else if (linger_cnt > 0) linger_cnt--;
        slave_ready = !(rdy_stall_at >= 0 && wr_count >= rdy_stall_at);
        slave_valid = master_ready && (rd_idx < 8);
        rd_bus      = slave_valid ? rx_byte[7 - rd_idx] : 1'b0;
        if (master_valid && slave_ready && bgrant) begin
            wr_log = {wr_log[30:0], wr_bus};
            wr_count++;
        end
        if (slave_valid && master_ready) rd_idx++;
    endtask

    task automatic clear_model();
        wr_log        = 32'h0;
        wr_count      = 0;
        rd_idx        = 0;
        rsp_count     = 0;
        mv_in_rd      = 0;
        accept_count  = 0;
        grant_drop_at = -1;
        rdy_stall_at  = -1;
        grant_en      = 1'b1;
        ack_en        = 1'b1;
    endtask

    // Called right after a falling edge, so req_ready is stable here
    task automatic issue(input logic m, input logic [4:0] d, input logic [11:0] a,
                         input logic [7:0] w, input logic clr);
        req_mode       = m;
        req_dev        = d;
        req_addr       = a;
        req_wdata      = w;
        req_valid      = 1'b1;
        auto_clear     = clr;
        accept_pending = req_ready;
        if (accept_pending) accept_count++;
    endtask

    task automatic run_until_rsp(input int max_ticks);
        int start;
        start = rsp_count;
        for (int i = 0; i < max_ticks; i++) begin
            tick();
            if (rsp_count != start) break;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"},    req_ready,    1);
        check({pfx, "_rsp_valid"},    rsp_valid,    0);
        check({pfx, "_rsp_err"},      rsp_err,      0);
        check({pfx, "_breq"},         breq,         0);
        check({pfx, "_mode"},         mode,         0);
        check({pfx, "_wr_bus"},       wr_bus,       0);
        check({pfx, "_master_valid"}, master_valid, 0);
        check({pfx, "_master_ready"}, master_ready, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_dev = 5'd0;
        req_addr = 12'h000; req_wdata = 8'h00; bgrant = 1'b0; slave_ready = 1'b0;
        rd_bus = 1'b0; slave_valid = 1'b0; ack = 1'b0;
        ack_linger = 0; linger_cnt = 0; rx_byte = 8'h00; accept_pending = 1'b0;
        auto_clear = 1'b1; last_err = 2'b00; last_rdata = 8'h00; last_breq = 1'b0;
        last_mv = 1'b0; zero_ticks = 0;
        clear_model();

        // reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        rst = 1'b0;
        tick();

        // write: dev 00000, addr A5C, data 3C
        clear_model();
        issue(1'b1, 5'b00000, 12'hA5C, 8'h3C, 1'b1);
        run_until_rsp(100);
        check("wr_rsp_count", rsp_count, 1);
        check("wr_rsp_err", last_err, 2'b00);
        check("wr_breq_in_done", last_breq, 0);
        check("wr_bit_count", wr_count, 25);
        check("wr_bits", wr_log, {7'b0, 5'b00000, 12'hA5C, 8'h3C});
        repeat (3) tick();
        check("wr_single_pulse", rsp_count, 1);
        check("wr_back_idle", req_ready, 1);

        // read: dev 00010, addr 001, slave returns C3
        clear_model();
        rx_byte = 8'hC3;
        issue(1'b0, 5'b00010, 12'h001, 8'h00, 1'b1);
        run_until_rsp(100);
        check("rd_rsp_err", last_err, 2'b00);
        check("rd_rdata", last_rdata, 8'hC3);
        check("rd_mv_low_in_rdata", mv_in_rd, 0);
        check("rd_bits_taken", rd_idx, 8);
        check("rd_bits_sent", wr_log, {15'b0, 5'b00010, 12'h001});
        check("rd_bit_count", wr_count, 17);
        repeat (3) tick();

        // nack: ack held low
        clear_model();
        ack_en = 1'b0;
        issue(1'b1, 5'b01000, 12'hFFF, 8'hFF, 1'b1);
        run_until_rsp(100);
        check("nack_err", last_err, 2'b01);
        check("nack_bit_count", wr_count, 6);
        check("nack_bits", wr_log, {26'b0, 5'b01000, 1'b1});
        tick();
        check("nack_release_busy", req_ready, 0);
        tick();
        check("nack_idle_2cyc", req_ready, 1);
        check("nack_rdata_hold", rsp_rdata, 8'hC3);

        // grant lost after 3 local-address bits
        clear_model();
        grant_drop_at = 8;
        issue(1'b1, 5'b00000, 12'hA5C, 8'h3C, 1'b1);
        run_until_rsp(100);
        check("lost_err", last_err, 2'b10);
        check("lost_bit_count", wr_count, 8);
        check("lost_mv_in_done", last_mv, 0);
        grant_drop_at = -1;
        grant_en = 1'b1;
        repeat (3) tick();
        check("lost_back_idle", req_ready, 1);

        // back-to-back with ack lingering three cycles after breq drops
        clear_model();
        ack_linger = 3;
        issue(1'b1, 5'b00000, 12'h123, 8'h5A, 1'b0);
        run_until_rsp(100);
        check("b2b_first_err", last_err, 2'b00);
        check("b2b_first_accepts", accept_count, 1);
        zero_ticks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_ready) break;
            zero_ticks++;
        end
        check("b2b_ready_wait", zero_ticks, 3);
        check("b2b_second_accept", accept_count, 2);
        auto_clear = 1'b1;
        wr_log = 32'h0;
        wr_count = 0;
        run_until_rsp(100);
        check("b2b_second_rsp", rsp_count, 2);
        check("b2b_second_err", last_err, 2'b00);
        check("b2b_second_bits", wr_log, {7'b0, 5'b00000, 12'h123, 8'h5A});
        ack_linger = 0;
        repeat (6) tick();
        check("b2b_idle", req_ready, 1);

        // stall in MEM_ADDR
        clear_model();
        rdy_stall_at = 8;
        issue(1'b1, 5'b00000, 12'hA5C, 8'h3C, 1'b1);
`ifdef SMP_TIMEOUT_EN
        run_until_rsp(150);
        check("to_rsp", rsp_count, 1);
        check("to_err", last_err, 2'b11);
        check("to_bit_count", wr_count, 8);
`else
        repeat (200) tick();
        check("stall_no_rsp", rsp_count, 0);
        check("stall_mv_held", master_valid, 1);
        check("stall_breq_held", breq, 1);
        check("stall_bit_count", wr_count, 8);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // reset asserted in the middle of WDATA
        clear_model();
        rdy_stall_at = 20;
        issue(1'b1, 5'b00000, 12'hA5C, 8'h3C, 1'b1);
        repeat (40) tick();
        check("wd_mv_before_rst", master_valid, 1);
        check("wd_mode_before_rst", mode, 1);
        check("wd_bits_before_rst", wr_count, 20);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
